matrix_mem_arbiter: RTL

MATRIX_MEM_ARBITER -- requirements
Module: matrix_mem_arbiter

---
 rtl/matrix_mem_arbiter_if.sv | 31 +++
 rtl/matrix_mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/matrix_mem_arbiter_if.sv
// Request/grant and storage-access bundle for matrix_mem_arbiter.
// The master modport is the arbiter side; the slave modport is the requesters plus storage.
interface matrix_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [3:0]          req;
    logic [3:0]          req_we;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_wdata;
    logic [3:0]          gnt;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic [DATA_W-1:0]   rd_data;
    logic [3:0]          rd_valid;
    logic [1:0]          owner;
    logic                busy;

    modport master (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_data, rd_valid, owner, busy
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_data, rd_valid, owner, busy
    );
endinterface

// File: rtl/matrix_mem_arbiter.sv
// Four-requester arbiter for the shared matrix storage with burst limiting and read-return steering.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed top priority.
module matrix_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_mem_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        owner_q, owner_d;
    logic [7:0]        burst_q, burst_d;
    logic [3:0]        rd_valid_q, rd_valid_d;
    logic [1:0]        search_start;
    logic [2:0]        pick_res;
    logic              access;
    logic              others_pending;
    logic [DATA_W-1:0] wdata_sel;

    // Returns {found, index} of the first set request scanning upward from start, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign search_start = rr_ptr_q;
    assign rr_ptr_d     = (state_q == S_IDLE && pick_res[2]) ? pick_res[1:0] + 2'd1 : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 2'd0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    assign search_start = 2'd0;
`endif

    assign pick_res       = pick(bus.req, search_start);
    assign access         = (state_q == S_BUSY) && bus.req[owner_q];
    assign others_pending = |(bus.req & ~gnt_q);
    assign wdata_sel      = bus.req_wdata[int'(owner_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        rd_valid_d = '0;
        if (access && !bus.req_we[owner_q]) rd_valid_d = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_res[2]) begin
                    state_d = S_BUSY;
                    gnt_d   = 4'b0001 << pick_res[1:0];
                    owner_d = pick_res[1:0];
                    burst_d = 8'd0;
                end
            end
            S_BUSY: begin
                if (!access) begin
                    state_d = S_DRAIN;
                    gnt_d   = 4'b0000;
                end else if (burst_q == BURST_LAST) begin
                    // Burst limit reached: release only if someone else is waiting, else wrap and keep going.
                    burst_d = 8'd0;
                    if (others_pending) begin
                        state_d = S_DRAIN;
                        gnt_d   = 4'b0000;
                    end
                end else begin
                    burst_d = burst_q + 8'd1;
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 4'b0000;
            owner_q    <= 2'd0;
            burst_q    <= 8'd0;
            rd_valid_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.mem_en    = access;
    assign bus.mem_we    = access & bus.req_we[owner_q];
    assign bus.mem_addr  = bus.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    assign bus.mem_wdata = wdata_sel;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q == S_BUSY);

endmodule
